// File: rtl/cache_test_seq.sv
// Programmable transaction sequencer for a cache CPU port: replays a small program of
// read/write entries, captures read data and counts read-compare failures.
module cache_test_seq #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [IW-1:0]     prog_idx,
  input  logic              prog_wr_rd,
  input  logic              prog_chk,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [IW:0]       len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] Address_cpu,
  output logic              wr_rd_cpu,
  output logic              cs_cpu,
  output logic [DATA_W-1:0] din_cpu,
  input  logic [DATA_W-1:0] DOut_cpu,
  input  logic              rdy_cpu,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic [7:0]        mismatch_cnt,
  output logic [IW-1:0]     fail_idx,
  output logic [15:0]       pass_cnt,
  input  logic [IW-1:0]     cap_idx,
  output logic [DATA_W-1:0] cap_data
);

  localparam int unsigned LW = IW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT);
  localparam logic [LW-1:0] DepthVal   = LW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [LW-1:0]     len_q, len_d;
  logic              loop_q, loop_d;
  logic              abort_q, abort_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [7:0]        mism_q, mism_d;
  logic [IW-1:0]     fail_q, fail_d;
  logic [15:0]       pass_q, pass_d;
  logic              cs_q, cs_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_rd_q, wr_rd_d;
  logic [DATA_W-1:0] din_q, din_d;

  // Program memory is deliberately left out of reset so it survives a reset pulse.
  logic              mem_wr_rd [DEPTH];
  logic              mem_chk   [DEPTH];
  logic [ADDR_W-1:0] mem_addr  [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [DATA_W-1:0] cap_q     [DEPTH];

  logic              prog_open;
  logic              last;
  logic              abort_now;
  logic              rd_mismatch;
  logic [CW-1:0]     wait_inc;
  logic              issue;
  logic [IW-1:0]     issue_idx;
  logic              cap_we;

  assign prog_open   = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr);
  assign last        = ({1'b0, idx_q} == (len_q - LW'(1)));
  assign abort_now   = abort_q | abort;
  assign rd_mismatch = mem_chk[idx_q] && (DOut_cpu != mem_data[idx_q]);
  assign wait_inc    = wait_q + CW'(1);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    loop_d    = loop_q;
    abort_d   = abort_q;
    wait_d    = wait_q;
    mism_d    = mism_q;
    fail_d    = fail_q;
    pass_d    = pass_q;
    cs_d      = 1'b0;
    addr_d    = addr_q;
    wr_rd_d   = wr_rd_q;
    din_d     = din_q;
    issue     = 1'b0;
    issue_idx = '0;
    cap_we    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        abort_d = 1'b0;
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          len_d  = (len > DepthVal) ? DepthVal : len;
          loop_d = loop_en;
          mism_d = '0;
          fail_d = '0;
          pass_d = '0;
          if (len == '0) begin
            state_d = StDone;
          end else begin
            issue = 1'b1;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        wait_d  = '0;
        if (abort) abort_d = 1'b1;
      end
      StWait: begin
        if (abort) abort_d = 1'b1;
        if (rdy_cpu) begin
          if (!wr_rd_q) begin
            cap_we = 1'b1;
            if (rd_mismatch) begin
              if (mism_q == 8'd0) fail_d = idx_q;
              if (mism_q != 8'hFF) mism_d = mism_q + 8'd1;
            end
          end
          if (last && loop_q) pass_d = pass_q + 16'd1;
          if (abort_now) begin
            state_d = StIdle;
          end else if (!last) begin
            issue     = 1'b1;
            issue_idx = idx_q + IW'(1);
          end else if (loop_q) begin
            issue = 1'b1;
          end else begin
            state_d = StDone;
          end
        end else if (wait_inc == TimeoutVal) begin
          // A pending abort wins over reporting the timeout.
          state_d = abort_now ? StIdle : StErr;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: state_d = StIdle;
    endcase

    if (issue) begin
      state_d = StIssue;
      idx_d   = issue_idx;
      cs_d    = 1'b1;
      addr_d  = mem_addr[issue_idx];
      wr_rd_d = mem_wr_rd[issue_idx];
      din_d   = mem_data[issue_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      abort_q <= 1'b0;
      wait_q  <= '0;
      mism_q  <= '0;
      fail_q  <= '0;
      pass_q  <= '0;
      cs_q    <= 1'b0;
      addr_q  <= '0;
      wr_rd_q <= 1'b0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
      mism_q  <= mism_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      wr_rd_q <= wr_rd_d;
      din_q   <= din_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) cap_q[i] <= '0;
    end else if (cap_we) begin
      cap_q[idx_q] <= DOut_cpu;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && prog_open) begin
      mem_wr_rd[prog_idx] <= prog_wr_rd;
      mem_chk[prog_idx]   <= prog_chk;
      mem_addr[prog_idx]  <= prog_addr;
      mem_data[prog_idx]  <= prog_data;
    end
  end

  assign Address_cpu  = addr_q;
  assign wr_rd_cpu    = wr_rd_q;
  assign cs_cpu       = cs_q;
  assign din_cpu      = din_q;
  assign busy         = (state_q == StIssue) || (state_q == StWait);
  assign done         = (state_q == StDone);
  assign err_timeout  = (state_q == StErr);
  assign mismatch_cnt = mism_q;
  assign fail_idx     = fail_q;
  assign pass_cnt     = pass_q;
  assign cap_data     = cap_q[cap_idx];

endmodule

// File: doc/cache_test_seq.md
CACHE_TEST_SEQ -- requirements
Module: cache_test_seq

Parameters
REQ-001 The block SHALL have parameter ADDR_W, default 16, meaning the CPU-port address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the CPU-port data width.
REQ-003 The block SHALL have parameter DEPTH, default 8 (power of two, at least 2), meaning the number of program and capture entries; IW = log2(DEPTH).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of WAIT cycles per transaction.

Interface
REQ-005 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-006 The ports SHALL be:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  write one program entry.
- prog_idx  in  IW  program entry index.
- prog_wr_rd  in  1  1 = write transaction, 0 = read transaction.
- prog_chk  in  1  compare read data against prog_data.
- prog_addr  in  ADDR_W  transaction address.
- prog_data  in  DATA_W  write data, or expected read data.
- len  in  IW+1  number of entries to run.
- loop_en  in  1  repeat the program continuously.
- start  in  1  begin a run.
- abort  in  1  stop a run.
- Address_cpu  out  ADDR_W  cache CPU address.
- wr_rd_cpu  out  1  cache CPU write/read select.
- cs_cpu  out  1  cache CPU chip select.
- din_cpu  out  DATA_W  data to cache.
- DOut_cpu  in  DATA_W  data from cache.
- rdy_cpu  in  1  cache transaction complete.
- busy  out  1  run in progress.
- done  out  1  run finished.
- err_timeout  out  1  a transaction timed out.
- mismatch_cnt  out  8  read-compare failures.
- fail_idx  out  IW  entry index of the first compare failure.
- pass_cnt  out  16  completed loop passes.
- cap_idx  in  IW  capture readout index.
- cap_data  out  DATA_W  captured read data at cap_idx.

Function
REQ-007 prog_we SHALL write entry prog_idx on the clock edge only when the block is in IDLE, DONE or ERR; prog_we SHALL be ignored while busy.
REQ-008 The state machine SHALL have states IDLE, ISSUE, WAIT, DONE and ERR, and all CPU-side outputs SHALL be registered.
REQ-009 A start sampled in IDLE, DONE or ERR SHALL:
- latch len (values above DEPTH clamped to DEPTH) and loop_en;
- clear mismatch_cnt, fail_idx, pass_cnt and err_timeout;
- set the entry index to 0 and enter ISSUE.
REQ-010 A start with latched len = 0 SHALL go directly to DONE without asserting cs_cpu.
REQ-011 In ISSUE, cs_cpu SHALL be 1 for exactly one cycle, with Address_cpu, wr_rd_cpu and din_cpu driven from the current entry; the next state SHALL be WAIT.
REQ-012 In WAIT, cs_cpu SHALL be 0, Address_cpu, wr_rd_cpu and din_cpu SHALL hold their values, and a wait counter SHALL increment each cycle.
REQ-013 rdy_cpu sampled high in WAIT SHALL complete the transaction.
- For a read entry, DOut_cpu SHALL be stored into capture[index].
- For a read entry with chk = 1 and DOut_cpu != prog_data, mismatch_cnt SHALL increment, saturating at 255.
- fail_idx SHALL record the index of the first such failure only.
REQ-014 After a completion, if the entry is not the last, the index SHALL increment and the next state SHALL be ISSUE; cs_cpu re-asserts on the cycle after rdy_cpu is sampled.
REQ-015 After the last entry (index = len-1):
- with loop_en = 0, the next state SHALL be DONE;
- with loop_en = 1, the index SHALL wrap to 0, pass_cnt SHALL increment (wrapping at 2^16), and the next state SHALL be ISSUE.
REQ-016 If the wait counter reaches TIMEOUT without rdy_cpu, the next state SHALL be ERR and err_timeout SHALL be set.
REQ-017 rdy_cpu high in the same cycle that the counter reaches TIMEOUT SHALL count as a completion, not a timeout.
REQ-018 abort in IDLE, DONE or ERR SHALL go to IDLE on the next edge and clear done and err_timeout.
REQ-019 abort in ISSUE or WAIT SHALL be latched and take effect at the end of the current transaction (completion or timeout), going to IDLE; no further cs_cpu SHALL be issued.
REQ-020 abort and start asserted together SHALL be resolved in favour of abort.
REQ-021 busy SHALL be 1 in ISSUE and WAIT and 0 otherwise.
REQ-022 done SHALL be 1 only in DONE; err_timeout SHALL be 1 only in ERR; both states SHALL be held until start or abort.
REQ-023 rdy_cpu outside WAIT SHALL be ignored.
REQ-024 cap_data SHALL be a combinational read of capture[cap_idx].

Reset
REQ-025 While rst_n = 0, the block SHALL be in IDLE, and Address_cpu, wr_rd_cpu, cs_cpu, din_cpu, busy, done, err_timeout, mismatch_cnt, fail_idx, pass_cnt and all capture entries SHALL be 0.
REQ-026 Program memory SHALL NOT be reset.
REQ-027 Reset asserted mid-transaction SHALL drop cs_cpu immediately (asynchronously).

Verification
REQ-028 Load entry 0 as write 0x0010 / 0xA5A5A5A5 and entry 1 as read 0x0010 with chk = 1; run len = 2 with a cache model where rdy comes 3 cycles after cs. Required: two one-cycle cs_cpu pulses, done = 1, mismatch_cnt = 0, capture[1] = 0xA5A5A5A5.
REQ-029 Same program, but the model returns 0x0 for the read. Required: mismatch_cnt = 1, fail_idx = 1.
REQ-030 Run with loop_en = 1, len = 2; abort after the third cs_cpu pulse. Required: pass_cnt = 1 and IDLE reached only after that transaction's rdy_cpu.
REQ-031 Run with a model that never returns rdy_cpu and TIMEOUT = 255. Required: ERR entered 255 cycles after the WAIT entry, err_timeout = 1, busy = 0.
REQ-032 Check the edge cases: len = 0 gives done with no cs_cpu; len = 15 with DEPTH = 8 runs 8 entries; prog_we while busy leaves memory unchanged.
REQ-033 Assert rst_n low during WAIT. Required: cs_cpu = 0, all outputs at reset values, capture entries cleared, and program memory intact.
